dcache_wb_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache inserted between the core's MEM/WB data-memory access and a line-wide main-memory port.
- The `miss` output drives the hazard unit's DCacheMiss input (currently tied 0), which stalls the pipeline until the access completes.
- Accesses are word-addressed with byte enables, matching the core's 4-bit store enable.
- Also keeps access/miss performance counters.

---
 rtl/dcache_wb_dm_if.sv | 33 +++
 rtl/dcache_wb_dm.sv | 130 +++++++++++++
 tb/tb_dcache_wb_dm.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_dm_if.sv
// Core-side access bus plus line-wide memory port of the direct-mapped data cache.
interface dcache_wb_dm_if #(
  parameter int LINE_ADDR_LEN = 3
);
  localparam int LINE_BITS = 32 << LINE_ADDR_LEN;

  logic                   rd_req;
  logic [3:0]             wr_req;
  logic [31:0]            addr;
  logic [31:0]            wr_data;
  logic [31:0]            rd_data;
  logic                   miss;
  logic                   mem_rd_req;
  logic                   mem_wr_req;
  logic [29-LINE_ADDR_LEN:0] mem_addr;
  logic [LINE_BITS-1:0]   mem_wr_line;
  logic [LINE_BITS-1:0]   mem_rd_line;
  logic                   mem_gnt;
  logic [31:0]            access_cnt;
  logic [31:0]            miss_cnt;

  modport slave (
    input  rd_req, wr_req, addr, wr_data, mem_rd_line, mem_gnt,
    output rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
           access_cnt, miss_cnt
  );

  modport master (
    output rd_req, wr_req, addr, wr_data, mem_rd_line, mem_gnt,
    input  rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
           access_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back / write-allocate data cache; hits complete in the
// request cycle, misses swap lines over a line-wide memory port.
//
// state      | meaning
// IDLE       | serving hits; a miss picks SWAP_OUT (dirty victim) or SWAP_IN
// SWAP_OUT   | victim line written back, waiting for mem_gnt
// SWAP_IN    | line fetch outstanding, mem_rd_line captured on mem_gnt
// SWAP_IN_OK | fetched line installed valid/clean, back to IDLE
module dcache_wb_dm #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input logic           clk,
  input logic           rst,
  dcache_wb_dm_if.slave bus
);
  localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
  localparam int SET_NUM    = 1 << SET_ADDR_LEN;
  localparam int LINE_BITS  = 32 * LINE_WORDS;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SWAP_OUT   = 2'd1;
  localparam logic [1:0] SWAP_IN    = 2'd2;
  localparam logic [1:0] SWAP_IN_OK = 2'd3;

  logic [1:0]              state;
  logic [LINE_BITS-1:0]    dataMem [SET_NUM];
  logic [TAG_ADDR_LEN-1:0] tagMem [SET_NUM];
  logic [SET_NUM-1:0]      validMem;
  logic [SET_NUM-1:0]      dirtyMem;
  logic [LINE_BITS-1:0]    lineBuf;
  logic [TAG_ADDR_LEN-1:0] missTag;
  logic [SET_ADDR_LEN-1:0] missSet;
  logic [31:0]             accessCnt;
  logic [31:0]             missCnt;

  logic [LINE_ADDR_LEN-1:0] wordOff;
  logic [SET_ADDR_LEN-1:0]  setIdx;
  logic [TAG_ADDR_LEN-1:0]  reqTag;
  logic [LINE_BITS-1:0]     curLine;
  logic [31:0]              curWord;
  logic [31:0]              mergedWord;
  logic                     req;
  logic                     hit;
  logic                     idleHit;
  logic                     storeHit;
  logic                     unusedAddrBits;

  assign wordOff        = bus.addr[LINE_ADDR_LEN+1:2];
  assign setIdx         = bus.addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign reqTag         = bus.addr[31 -: TAG_ADDR_LEN];
  assign unusedAddrBits = ^bus.addr[1:0];

  assign curLine  = dataMem[setIdx];
  assign curWord  = curLine[{wordOff, 5'b0} +: 32];
  assign req      = bus.rd_req || (bus.wr_req != 4'b0);
  assign hit      = validMem[setIdx] && (tagMem[setIdx] == reqTag);
  assign idleHit  = (state == IDLE) && hit;
  assign storeHit = idleHit && (bus.wr_req != 4'b0);

  assign bus.miss        = req && !idleHit;
  assign bus.rd_data     = idleHit ? curWord : 32'b0;
  assign bus.mem_wr_req  = (state == SWAP_OUT);
  assign bus.mem_rd_req  = (state == SWAP_IN);
  assign bus.mem_wr_line = dataMem[missSet];
  assign bus.access_cnt  = accessCnt;
  assign bus.miss_cnt    = missCnt;

  // Miss set/tag are latched so the swap completes even if the core drops the request.
  assign bus.mem_addr = (state == SWAP_OUT) ? {tagMem[missSet], missSet} :
                        (state == SWAP_IN)  ? {missTag, missSet} :
                                              {reqTag, setIdx};

  always_comb begin
    mergedWord = curWord;
    for (int b = 0; b < 4; b++) begin
      if (bus.wr_req[b]) mergedWord[8*b +: 8] = bus.wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      validMem  <= '0;
      dirtyMem  <= '0;
      accessCnt <= '0;
      missCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            missCnt <= missCnt + 32'd1;
            missTag <= reqTag;
            missSet <= setIdx;
            state   <= (validMem[setIdx] && dirtyMem[setIdx]) ? SWAP_OUT : SWAP_IN;
          end else if (storeHit) begin
            dirtyMem[setIdx] <= 1'b1;
          end
        end
        SWAP_OUT: begin
          if (bus.mem_gnt) state <= SWAP_IN;
        end
        SWAP_IN: begin
          if (bus.mem_gnt) begin
            lineBuf <= bus.mem_rd_line;
            state   <= SWAP_IN_OK;
          end
        end
        SWAP_IN_OK: begin
          validMem[missSet] <= 1'b1;
          dirtyMem[missSet] <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (req && idleHit) accessCnt <= accessCnt + 32'd1;
    end
  end

  // Line data and tags carry no reset; validMem alone decides what is usable.
  always_ff @(posedge clk) begin
    if (storeHit) begin
      dataMem[setIdx][{wordOff, 5'b0} +: 32] <= mergedWord;
    end else if (state == SWAP_IN_OK) begin
      dataMem[missSet] <= lineBuf;
      tagMem[missSet]  <= missTag;
    end
  end
endmodule

// File: tb/tb_dcache_wb_dm.sv
// Self-checking bench: directed scenarios plus random loads/stores against a
// set/tag/line reference cache and a sparse main-memory model.
module tb_dcache_wb_dm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wb_dm_if #(.LINE_ADDR_LEN(3)) bus ();

  dcache_wb_dm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nCompared = 0;
  int nMismatched = 0;

  logic [255:0] memModel [logic [26:0]];
  logic         mValid [4];
  logic         mDirty [4];
  logic [24:0]  mTag [4];
  logic [255:0] mData [4];
  logic [31:0]  mAccess;
  logic [31:0]  mMiss;

  task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] randLine();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] memRead(input logic [26:0] la);
    if (!memModel.exists(la)) memModel[la] = randLine();
    return memModel[la];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    mAccess = '0;
    mMiss   = '0;
  endtask

  // One complete access: present it, play the memory side of any miss, check,
  // then let the completing cycle clock through and drop the request.
  task automatic doAccess(input logic isRd, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] d, input int dly, output logic [31:0] rdObs);
    logic [1:0]   si;
    logic [2:0]   wi;
    logic [24:0]  tg;
    logic [26:0]  la;
    logic [26:0]  victimAddr;
    logic [255:0] victimLine;
    logic         hitExp, wbExp, sawWr, sawRd;
    int           gd, cnt, base;
    si = a[6:5];
    wi = a[4:2];
    tg = a[31:7];
    la = a[31:5];
    @(negedge clk);
    bus.rd_req = isRd; bus.wr_req = be; bus.addr = a; bus.wr_data = d; bus.mem_gnt = 1'b0;
    #1;
    checkVal("access_cnt", bus.access_cnt, mAccess);
    checkVal("miss_cnt", bus.miss_cnt, mMiss);
    hitExp = mValid[si] && (mTag[si] == tg);
    checkVal("miss", bus.miss, !hitExp);
    if (!hitExp) begin
      wbExp      = mValid[si] && mDirty[si];
      victimAddr = {mTag[si], si};
      victimLine = mData[si];
      mMiss++;
      gd = (dly < 0) ? $urandom_range(0, 3) : dly;
      cnt = 0; sawWr = 1'b0; sawRd = 1'b0;
      for (int cyc = 0; cyc < 60 && bus.miss; cyc++) begin
        if (bus.mem_wr_req) begin
          checkVal("wb_addr", bus.mem_addr, victimAddr);
          checkVal("wb_line", bus.mem_wr_line, victimLine);
          checkVal("wb_rd_excl", bus.mem_rd_req, 1'b0);
          sawWr = 1'b1;
          if (cnt == gd) begin
            bus.mem_gnt = 1'b1; memModel[victimAddr] = victimLine; cnt = 0;
          end else cnt++;
        end else if (bus.mem_rd_req) begin
          if (!sawRd) checkVal("wb_before_fill", sawWr, wbExp);
          checkVal("fill_addr", bus.mem_addr, la);
          checkVal("rd_data_busy", bus.rd_data, 32'h0);
          sawRd = 1'b1;
          if (cnt == gd) begin
            bus.mem_gnt = 1'b1; bus.mem_rd_line = memRead(la); cnt = 0;
          end else cnt++;
        end else begin
          bus.mem_gnt = 1'($urandom_range(0, 1));
          bus.mem_rd_line = randLine();
        end
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
      end
      if (bus.miss) checkVal("miss_timeout", bus.miss, 1'b0);
      checkVal("wb_seen", sawWr, wbExp);
      checkVal("fill_seen", sawRd, 1'b1);
      mValid[si] = 1'b1; mDirty[si] = 1'b0; mTag[si] = tg; mData[si] = memRead(la);
    end
    base = 32 * int'(wi);
    rdObs = bus.rd_data;
    checkVal("rd_data", bus.rd_data, mData[si][base +: 32]);
    @(posedge clk);
    if (be != 4'b0) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mData[si][base + 8*b +: 8] = d[8*b +: 8];
      mDirty[si] = 1'b1;
    end
    mAccess++;
    #1;
    bus.rd_req = 1'b0;
    bus.wr_req = 4'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0]  rdObs;
    logic [255:0] l;
    logic [31:0]  a;
    rst = 1'b1;
    bus.rd_req = 1'b0; bus.wr_req = 4'b0; bus.addr = '0; bus.wr_data = '0;
    bus.mem_gnt = 1'b0; bus.mem_rd_line = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("rst_miss", bus.miss, 1'b0);
    checkVal("rst_mem_rd_req", bus.mem_rd_req, 1'b0);
    checkVal("rst_mem_wr_req", bus.mem_wr_req, 1'b0);
    checkVal("rst_access_cnt", bus.access_cnt, 32'h0);
    checkVal("rst_miss_cnt", bus.miss_cnt, 32'h0);

    // Cold load miss, word1 of line 1 preset
    l = randLine();
    l[63:32] = 32'hDEADBEEF;
    memModel[27'd1] = l;
    doAccess(1'b1, 4'b0, 32'h0000_0024, 32'h0, 3, rdObs);
    checkVal("cold_data", rdObs, 32'hDEADBEEF);

    // Store hit then load
    doAccess(1'b0, 4'b0011, 32'h0000_0024, 32'h1234_5678, -1, rdObs);
    doAccess(1'b1, 4'b0, 32'h0000_0024, 32'h0, -1, rdObs);
    checkVal("store_merge", rdObs, 32'hDEAD5678);

    // Dirty eviction, then clean eviction back to 0x24
    doAccess(1'b1, 4'b0, 32'h0000_0424, 32'h0, 1, rdObs);
    doAccess(1'b1, 4'b0, 32'h0000_0024, 32'h0, 2, rdObs);
    checkVal("evict_reload", rdObs, 32'hDEAD5678);

    // Reset while the fill is outstanding
    @(negedge clk);
    bus.rd_req = 1'b1; bus.addr = 32'h0000_0844;
    #1;
    for (int c = 0; c < 20 && !bus.mem_rd_req; c++) begin
      @(negedge clk); #1;
    end
    checkVal("rst_pre_fill", bus.mem_rd_req, 1'b1);
    @(negedge clk);
    rst = 1'b1; bus.rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    modelReset();
    checkVal("abort_mem_rd_req", bus.mem_rd_req, 1'b0);
    checkVal("abort_miss", bus.miss, 1'b0);
    checkVal("abort_access_cnt", bus.access_cnt, 32'h0);
    checkVal("abort_miss_cnt", bus.miss_cnt, 32'h0);
    doAccess(1'b1, 4'b0, 32'h0000_0844, 32'h0, -1, rdObs);

    // Access counter wrap
    @(negedge clk);
    force dut.accessCnt = 32'hFFFF_FFFF;
    #1;
    release dut.accessCnt;
    mAccess = 32'hFFFF_FFFF;
    doAccess(1'b1, 4'b0, 32'h0000_0848, 32'h0, -1, rdObs);
    @(negedge clk);
    #1;
    checkVal("access_wrap", bus.access_cnt, 32'h0);

    // Store dropped mid-fill: line installed clean, store discarded
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 4'hF; bus.wr_data = 32'hCAFE_F00D; bus.addr = 32'h0000_1844;
    #1;
    checkVal("drop_miss", bus.miss, 1'b1);
    for (int c = 0; c < 20 && !bus.mem_rd_req; c++) begin
      @(negedge clk); #1;
    end
    checkVal("drop_fill_req", bus.mem_rd_req, 1'b1);
    bus.wr_req = 4'b0;
    #1;
    checkVal("drop_no_miss", bus.miss, 1'b0);
    bus.mem_gnt = 1'b1;
    bus.mem_rd_line = memRead(27'h0C2);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("drop_idle", bus.mem_rd_req, 1'b0);
    checkVal("drop_access_cnt", bus.access_cnt, mAccess);
    mMiss++;
    mValid[2] = 1'b1; mDirty[2] = 1'b0; mTag[2] = 25'h30; mData[2] = memRead(27'h0C2);
    doAccess(1'b1, 4'b0, 32'h0000_1844, 32'h0, -1, rdObs);
    doAccess(1'b1, 4'b0, 32'h0000_0844, 32'h0, -1, rdObs);

    // Random mix over a small tag pool to force hits, conflicts and dirty evictions
    for (int n = 0; n < 200; n++) begin
      logic [3:0] be;
      logic       rd;
      int         kind;
      a = {23'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      a[31:30] = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      be = (kind == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      doAccess(rd, be, a, $urandom, -1, rdObs);
    end
    @(negedge clk);
    #1;
    checkVal("final_access_cnt", bus.access_cnt, mAccess);
    checkVal("final_miss_cnt", bus.miss_cnt, mMiss);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
